vs_dict_proc_driver: RTL and testbench
======================================

# vs_dict_proc_driver

Driver-side endpoint of `vs_dict_proc_if` that sequences the sensing-matrix processor on behalf of a host. Owns the residual memory (served on `read_addr`/`read_data`), the inner-product (correlation) memory (filled from `write_*`), and streams sensing-matrix cells from an external source port during matrix load. Sits between the OMP top-level controller and `vs_sensing_matrix_processor`.

## Interface
- `ROWS`, 64, residual length / matrix rows
- `COLUMNS`, 256, matrix columns / correlation memory depth
- `BATCH_SIZE`, ROWS, inner products per processor batch
- `clock` in 1 rising-edge clock
- `reset` in 1 synchronous, active-high reset
- `bus` modport `vs_dict_proc_if.driver` — start, done, read_addr, read_data, write_enable, write_addr, write_data, command, batch_products_transferred
- `host_start` in 1 one-cycle operation request
- `host_cmd` in `vs_sensing_matrix_command_t` operation, sampled with `host_start`
- `host_busy` out 1 operation in progress
- `host_done` out 1 one-cycle completion pulse
- `host_error` out 1 sticky; set if correlation write count ≠ COLUMNS at compute done
- `host_res_we` in 1 residual write strobe
- `host_res_addr` in 8 residual write address
- `host_res_wdata` in FP_DATA_BUS_WIDTH residual value (fp_32_t, Q15)
- `host_corr_addr` in 8 correlation read address
- `host_corr_rdata` out FP_DATA_BUS_WIDTH correlation value, 1-cycle latency
- `mat_addr` out 16 matrix source address, column-major (col*ROWS+row)
- `mat_data` in FP_DATA_BUS_WIDTH matrix source data, valid 1 cycle after `mat_addr`
- `max_value` out FP_DATA_BUS_WIDTH signed value of largest |correlation| (see Configuration)
- `max_index` out 8 correlation index of `max_value`

## Operation
- States: IDLE, MAT_LOAD, IP_RUN, FINISH.
- IDLE: `host_start` with LOAD_SENSING_MATRIX → drive `bus.command`, pulse `bus.start` 1 cycle, zero `mat_addr`, → MAT_LOAD. With COMPUTE_INNER_PRODUCTS → drive command, pulse start, clear write counter, max tracker, `host_error`, → IP_RUN. Unknown command ignored.
- `host_start` while `host_busy` ignored. `bus.command` held stable from start until next accepted operation.
- MAT_LOAD: `mat_addr` = k in the k-th cycle after start cycle (k=0 in start cycle); `bus.read_data` = `mat_data` combinationally. `mat_addr` saturates at ROWS*COLUMNS-1. `bus.done` → FINISH.
- IP_RUN: `bus.read_data` registered = residual[`bus.read_addr`]; addresses ≥ ROWS return 0. Each cycle with `bus.write_enable`: correlation[`bus.write_addr` mod COLUMNS] ← `bus.write_data`, write counter +1 (saturating at 511). `bus.batch_products_transferred` pulses counted (debug only, not exported). `bus.done` → FINISH.
- FINISH: pulse `host_done`; set `host_error` if compute and counter ≠ COLUMNS; → IDLE.
- Residual writes accepted only when not busy; ignored while busy. Address ≥ ROWS ignored.
- Correlation memory readable by host at all times; read of address being written same cycle returns old value.

## Timing
- Reset values: `bus.start`=0, `bus.command`=LOAD_SENSING_MATRIX, `bus.read_data`=0, `host_busy`=0, `host_done`=0, `host_error`=0, `host_corr_rdata`=0, `mat_addr`=0, `max_value`=0, `max_index`=0. Memory contents not cleared.
- `host_start` at cycle t → `bus.start` high cycle t+1; `host_busy` high t+1 through FINISH cycle.
- Load: processor captures cell k at end of cycle t+2+k; `bus.done` seen → `host_done` next cycle.
- Reset mid-operation: immediate return to IDLE, start deasserted, no `host_done`; partially written correlation data retained.
- `bus.done` in IDLE ignored.

## Configuration
- `VS_DICT_DRIVER_MAXSCAN_EN` defined: on every correlation write, if |write_data| > current |max| (strict, two's complement; most-negative value treated as max magnitude), update `max_value`/`max_index`; ties keep lower index. Valid from FINISH.
- Undefined: tracker absent, `max_value`/`max_index` tied 0; host uses `vs_max_identifier` instead.

## Structure
- Shared package: `vs_sensing_matrix_command_t`, `fp_32_t`, `FP_DATA_BUS_WIDTH`, new `vs_dict_driver_state_t`.
- One sub-module: `vs_dual_port_ram` (1 write, 1 sync read port), instantiated twice (residual ROWS deep, correlation COLUMNS deep).

## Test plan
- Reset then idle 10 cycles → all outputs at reset values, `bus.start` never high.
- Load with `mat_data`=address → `mat_addr` 0..16383 sequential, processor phi[r][c]=c*64+r, one `host_done`.
- Residual all 1.0 (0x8000), phi column j = j/256 → correlation[j] matches, `host_error`=0.
- Processor model emits 255 writes → `host_error`=1 after `host_done`.
- MAXSCAN_EN, correlations with −3.0 at index 17 and +3.0 at index 40 → `max_index`=17, `max_value`=−3.0.
- Reset asserted mid-IP_RUN, then new compute → no stale `host_done`, second run completes normally.

Source files
------------

// File: rtl/vs_dict_proc_driver_pkg.sv
// Shared types for the dictionary-processor driver: data format, processor
// commands and the driver FSM state encoding.
package vs_dict_proc_driver_pkg;

  localparam int FP_DATA_BUS_WIDTH = 32;
  localparam int BUS_ADDR_WIDTH    = 8;
  localparam int CORR_COUNT_WIDTH  = 9;

  typedef logic signed [FP_DATA_BUS_WIDTH-1:0] fp_32_t;

  typedef enum logic [1:0] {
    LOAD_SENSING_MATRIX    = 2'd0,
    COMPUTE_INNER_PRODUCTS = 2'd1
  } vs_sensing_matrix_command_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MAT_LOAD = 2'd1,
    IP_RUN   = 2'd2,
    FINISH   = 2'd3
  } vs_dict_driver_state_t;

  // One extra bit so the most-negative value maps to the largest magnitude.
  function automatic logic [FP_DATA_BUS_WIDTH:0] fp_magnitude(input fp_32_t v);
    logic [FP_DATA_BUS_WIDTH:0] ext;
    ext = {v[FP_DATA_BUS_WIDTH-1], v};
    return v[FP_DATA_BUS_WIDTH-1] ? (~ext + {{FP_DATA_BUS_WIDTH{1'b0}}, 1'b1}) : ext;
  endfunction

endpackage

// File: rtl/vs_dict_proc_if.sv
// Handshake and memory bus between the dictionary driver and the
// sensing-matrix processor.
interface vs_dict_proc_if;
  import vs_dict_proc_driver_pkg::*;

  logic                       start;
  logic                       done;
  logic [BUS_ADDR_WIDTH-1:0]  read_addr;
  fp_32_t                     read_data;
  logic                       write_enable;
  logic [BUS_ADDR_WIDTH-1:0]  write_addr;
  fp_32_t                     write_data;
  vs_sensing_matrix_command_t command;
  logic                       batch_products_transferred;

  modport driver (
    output start, command, read_data,
    input  done, read_addr, write_enable, write_addr, write_data,
           batch_products_transferred
  );

  modport processor (
    input  start, command, read_data,
    output done, read_addr, write_enable, write_addr, write_data,
           batch_products_transferred
  );
endinterface

// File: rtl/vs_dual_port_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Same-address read/write in one cycle returns the previous contents.
module vs_dual_port_ram #(
  parameter int DEPTH      = 64,
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [WIDTH-1:0]      write_data,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [WIDTH-1:0]      read_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (write_enable) begin
      mem[write_addr] <= write_data;
    end
  end

  // Only the output register is reset; array contents survive reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      read_data <= '0;
    end else begin
      read_data <= mem[read_addr];
    end
  end

endmodule

// File: rtl/vs_dict_proc_driver.sv
// Driver-side endpoint of vs_dict_proc_if: residual/correlation memories,
// matrix streaming and host sequencing. Optional max tracker: VS_DICT_DRIVER_MAXSCAN_EN.
module vs_dict_proc_driver
  import vs_dict_proc_driver_pkg::*;
#(
  parameter int ROWS       = 64,
  parameter int COLUMNS    = 256,
  parameter int BATCH_SIZE = ROWS
) (
  input  logic                       clock,
  input  logic                       reset,
  vs_dict_proc_if.driver             bus,
  input  logic                       host_start,
  input  vs_sensing_matrix_command_t host_cmd,
  output logic                       host_busy,
  output logic                       host_done,
  output logic                       host_error,
  input  logic                       host_res_we,
  input  logic [7:0]                 host_res_addr,
  input  fp_32_t                     host_res_wdata,
  input  logic [7:0]                 host_corr_addr,
  output fp_32_t                     host_corr_rdata,
  output logic [15:0]                mat_addr,
  input  fp_32_t                     mat_data,
  output fp_32_t                     max_value,
  output logic [7:0]                 max_index
);

  localparam int RES_AW      = $clog2(ROWS);
  localparam int CORR_AW     = $clog2(COLUMNS);
  localparam int BATCH_CNT_W = $clog2(COLUMNS / BATCH_SIZE + 1) + 1;
  localparam logic [15:0] MAT_LAST   = 16'(ROWS * COLUMNS - 1);
  localparam logic [8:0]  ROWS_BOUND = 9'(ROWS);
  localparam logic [CORR_COUNT_WIDTH-1:0] COLUMNS_CNT = CORR_COUNT_WIDTH'(COLUMNS);

  vs_dict_driver_state_t         state;
  logic                          op_is_compute;
  logic [CORR_COUNT_WIDTH-1:0]   corr_writes;
  logic [BATCH_CNT_W-1:0]        batch_count;
  logic                          res_rd_valid;
  fp_32_t                        res_rdata;
  logic                          accept_load;
  logic                          accept_compute;
  logic                          res_we;
  logic                          corr_we;
  logic [CORR_AW-1:0]            corr_waddr;

  always_comb begin
    accept_load    = (state == IDLE) && host_start && (host_cmd == LOAD_SENSING_MATRIX);
    accept_compute = (state == IDLE) && host_start && (host_cmd == COMPUTE_INNER_PRODUCTS);
    res_we         = host_res_we && !host_busy && ({1'b0, host_res_addr} < ROWS_BOUND);
    corr_we        = (state == IP_RUN) && bus.write_enable;
    // COLUMNS is a power of two, so the low bits implement the modulo.
    corr_waddr     = bus.write_addr[CORR_AW-1:0];
  end

  always_comb begin
    bus.read_data = '0;
    if (state == MAT_LOAD) begin
      bus.read_data = mat_data;
    end else if (res_rd_valid) begin
      bus.read_data = res_rdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      res_rd_valid <= 1'b0;
    end else begin
      res_rd_valid <= (state == IP_RUN) && ({1'b0, bus.read_addr} < ROWS_BOUND);
    end
  end

  vs_dual_port_ram #(
    .DEPTH (ROWS),
    .WIDTH (FP_DATA_BUS_WIDTH)
  ) u_residual_ram (
    .clock        (clock),
    .reset        (reset),
    .write_enable (res_we),
    .write_addr   (host_res_addr[RES_AW-1:0]),
    .write_data   (host_res_wdata),
    .read_addr    (bus.read_addr[RES_AW-1:0]),
    .read_data    (res_rdata)
  );

  vs_dual_port_ram #(
    .DEPTH (COLUMNS),
    .WIDTH (FP_DATA_BUS_WIDTH)
  ) u_correlation_ram (
    .clock        (clock),
    .reset        (reset),
    .write_enable (corr_we),
    .write_addr   (corr_waddr),
    .write_data   (bus.write_data),
    .read_addr    (host_corr_addr[CORR_AW-1:0]),
    .read_data    (host_corr_rdata)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      bus.start     <= 1'b0;
      bus.command   <= LOAD_SENSING_MATRIX;
      host_busy     <= 1'b0;
      host_done     <= 1'b0;
      host_error    <= 1'b0;
      mat_addr      <= '0;
      op_is_compute <= 1'b0;
      corr_writes   <= '0;
      batch_count   <= '0;
    end else begin
      bus.start <= 1'b0;
      host_done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_load) begin
            bus.command   <= LOAD_SENSING_MATRIX;
            bus.start     <= 1'b1;
            host_busy     <= 1'b1;
            mat_addr      <= '0;
            op_is_compute <= 1'b0;
            state         <= MAT_LOAD;
          end else if (accept_compute) begin
            bus.command   <= COMPUTE_INNER_PRODUCTS;
            bus.start     <= 1'b1;
            host_busy     <= 1'b1;
            host_error    <= 1'b0;
            corr_writes   <= '0;
            batch_count   <= '0;
            op_is_compute <= 1'b1;
            state         <= IP_RUN;
          end
        end
        MAT_LOAD: begin
          if (mat_addr != MAT_LAST) begin
            mat_addr <= mat_addr + 16'd1;
          end
          if (bus.done) begin
            host_done <= 1'b1;
            state     <= FINISH;
          end
        end
        IP_RUN: begin
          if (bus.write_enable && (corr_writes != '1)) begin
            corr_writes <= corr_writes + CORR_COUNT_WIDTH'(1);
          end
          if (bus.batch_products_transferred) begin
            batch_count <= batch_count + BATCH_CNT_W'(1);
          end
          if (bus.done) begin
            host_done <= 1'b1;
            state     <= FINISH;
          end
        end
        FINISH: begin
          host_busy <= 1'b0;
          if (op_is_compute && (corr_writes != COLUMNS_CNT)) begin
            host_error <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef VS_DICT_DRIVER_MAXSCAN_EN
  logic [FP_DATA_BUS_WIDTH:0] wr_mag;
  logic [FP_DATA_BUS_WIDTH:0] max_mag;
  logic [7:0]                 wr_index;
  logic                       max_update;

  // Strictly larger magnitude wins; on a tie the lower index is kept.
  always_comb begin
    wr_mag     = fp_magnitude(bus.write_data);
    max_mag    = fp_magnitude(max_value);
    wr_index   = 8'(corr_waddr);
    max_update = corr_we &&
                 ((wr_mag > max_mag) || ((wr_mag == max_mag) && (wr_index < max_index)));
  end

  always_ff @(posedge clock) begin
    if (reset || accept_compute) begin
      max_value <= '0;
      max_index <= '0;
    end else if (max_update) begin
      max_value <= bus.write_data;
      max_index <= wr_index;
    end
  end
`else
  assign max_value = '0;
  assign max_index = '0;
`endif

endmodule

// File: tb/tb_vs_dict_proc_driver.sv
// Directed bench for vs_dict_proc_driver with a behavioural sensing-matrix
// processor driving the processor side of vs_dict_proc_if.
module tb_vs_dict_proc_driver;
  import vs_dict_proc_driver_pkg::*;

  localparam int ROWS    = 64;
  localparam int COLUMNS = 256;
  localparam int CELLS   = ROWS * COLUMNS;

  logic                       clock = 1'b0;
  logic                       reset;
  logic                       host_start;
  vs_sensing_matrix_command_t host_cmd;
  logic                       host_busy;
  logic                       host_done;
  logic                       host_error;
  logic                       host_res_we;
  logic [7:0]                 host_res_addr;
  fp_32_t                     host_res_wdata;
  logic [7:0]                 host_corr_addr;
  fp_32_t                     host_corr_rdata;
  logic [15:0]                mat_addr;
  fp_32_t                     mat_data;
  fp_32_t                     max_value;
  logic [7:0]                 max_index;
  logic                       mat_mode;

  int checks = 0;
  int errors = 0;
  int start_pulses = 0;
  int done_pulses = 0;
  fp_32_t phi [CELLS];

  always #5 clock = ~clock;

  vs_dict_proc_if bus_if ();

  vs_dict_proc_driver #(
    .ROWS       (ROWS),
    .COLUMNS    (COLUMNS),
    .BATCH_SIZE (ROWS)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .bus             (bus_if),
    .host_start      (host_start),
    .host_cmd        (host_cmd),
    .host_busy       (host_busy),
    .host_done       (host_done),
    .host_error      (host_error),
    .host_res_we     (host_res_we),
    .host_res_addr   (host_res_addr),
    .host_res_wdata  (host_res_wdata),
    .host_corr_addr  (host_corr_addr),
    .host_corr_rdata (host_corr_rdata),
    .mat_addr        (mat_addr),
    .mat_data        (mat_data),
    .max_value       (max_value),
    .max_index       (max_index)
  );

  // External matrix source: one-cycle read latency.
  always @(posedge clock) begin
    mat_data <= mat_mode ? fp_32_t'(32'(mat_addr[13:6]) << 7) : fp_32_t'(32'(mat_addr));
  end

  always @(posedge clock) begin
    if (bus_if.start) start_pulses <= start_pulses + 1;
    if (host_done)    done_pulses  <= done_pulses + 1;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } res_vec_t;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] exp;
  } corr_vec_t;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic host_op(input vs_sensing_matrix_command_t cmd);
    host_cmd   = cmd;
    host_start = 1'b1;
    step();
    host_start = 1'b0;
  endtask

  task automatic finish_op(input string tag);
    bus_if.done = 1'b1;
    step();
    bus_if.done = 1'b0;
    check({tag, "_host_done_pulse"}, host_done, 1);
    check({tag, "_busy_in_finish"}, host_busy, 1);
    step();
    check({tag, "_host_done_clear"}, host_done, 0);
    check({tag, "_busy_clear"}, host_busy, 0);
  endtask

  function automatic fp_32_t write_val(input int mode, input int j);
    fp_32_t v;
    v = fp_32_t'(32'hA000_0000 | 32'(j));
    if (mode == 1) begin
      v = fp_32_t'(32'(j));
      if (j == 5)              v = fp_32_t'(-32'sd1000);
      if (j == 17 || j == 90)  v = fp_32_t'(32'hFFFE_8000);
      if (j == 40)             v = fp_32_t'(32'h0001_8000);
    end
    return v;
  endfunction

  task automatic fast_writes(input int n, input int mode);
    for (int j = 0; j < n; j++) begin
      bus_if.write_enable = 1'b1;
      bus_if.write_addr   = 8'(j);
      bus_if.write_data   = write_val(mode, j);
      bus_if.batch_products_transferred = ((j % ROWS) == ROWS - 1);
      step();
    end
    bus_if.write_enable = 1'b0;
    bus_if.batch_products_transferred = 1'b0;
  endtask

  task automatic load_matrix(input logic mode, input string tag);
    int addr_err;
    int cell_err;
    int exp_addr;
    int exp_cell;
    addr_err = 0;
    cell_err = 0;
    mat_mode = mode;
    host_op(LOAD_SENSING_MATRIX);
    check({tag, "_start"}, bus_if.start, 1);
    check({tag, "_busy"}, host_busy, 1);
    check({tag, "_mat_addr0"}, mat_addr, 0);
    check({tag, "_command"}, bus_if.command, LOAD_SENSING_MATRIX);
    for (int k = 0; k < CELLS; k++) begin
      if (k == 100) begin
        host_cmd   = COMPUTE_INNER_PRODUCTS;
        host_start = 1'b1;
      end
      step();
      host_start = 1'b0;
      exp_addr = (k + 1 > CELLS - 1) ? CELLS - 1 : k + 1;
      if (mat_addr !== 16'(exp_addr)) addr_err++;
      phi[k] = bus_if.read_data;
      exp_cell = mode ? (k / ROWS) * 128 : k;
      if (bus_if.read_data !== fp_32_t'(exp_cell)) cell_err++;
    end
    check({tag, "_mat_addr_seq"}, addr_err, 0);
    check({tag, "_cells"}, cell_err, 0);
    finish_op(tag);
    check({tag, "_command_held"}, bus_if.command, LOAD_SENSING_MATRIX);
  endtask

  task automatic full_compute();
    int     rbw_err;
    longint acc;
    rbw_err = 0;
    for (int j = 0; j < COLUMNS; j++) begin
      acc = 0;
      for (int r = 0; r < ROWS; r++) begin
        bus_if.read_addr = 8'(r);
        step();
        acc += (longint'(bus_if.read_data) * longint'(phi[j * ROWS + r])) >>> 15;
      end
      host_corr_addr      = 8'(j);
      bus_if.write_enable = 1'b1;
      bus_if.write_addr   = 8'(j);
      bus_if.write_data   = fp_32_t'(acc);
      bus_if.batch_products_transferred = ((j % ROWS) == ROWS - 1);
      step();
      bus_if.write_enable = 1'b0;
      bus_if.batch_products_transferred = 1'b0;
      if (host_corr_rdata !== fp_32_t'(32'hA000_0000 | 32'(j))) rbw_err++;
    end
    check("corr_read_during_write_old", rbw_err, 0);
  endtask

  res_vec_t  rv [7];
  corr_vec_t cv [5];
  int        prev_done;

  initial begin
    rv[0] = '{8'd0,   32'h0000_1234, 32'h0000_1234};
    rv[1] = '{8'd5,   32'hFFFF_8000, 32'hFFFF_8000};
    rv[2] = '{8'd8,   32'h0000_0777, 32'h0000_0777};
    rv[3] = '{8'd63,  32'h7FFF_FFFF, 32'h7FFF_FFFF};
    rv[4] = '{8'd64,  32'hDEAD_BEEF, 32'h0000_0000};
    rv[5] = '{8'd200, 32'h1111_1111, 32'h0000_0000};
    rv[6] = '{8'd10,  32'h0000_8000, 32'h0000_8000};
    cv[0] = '{8'd0,   32'h0000_0000};
    cv[1] = '{8'd1,   32'h0000_2000};
    cv[2] = '{8'd17,  32'h0002_2000};
    cv[3] = '{8'd100, 32'h000C_8000};
    cv[4] = '{8'd255, 32'h001F_E000};

    reset = 1'b1;
    host_start = 1'b0;
    host_cmd = LOAD_SENSING_MATRIX;
    host_res_we = 1'b0;
    host_res_addr = '0;
    host_res_wdata = '0;
    host_corr_addr = '0;
    mat_mode = 1'b0;
    bus_if.done = 1'b0;
    bus_if.read_addr = '0;
    bus_if.write_enable = 1'b0;
    bus_if.write_addr = '0;
    bus_if.write_data = '0;
    bus_if.batch_products_transferred = 1'b0;

    repeat (3) step();
    check("rst_start", bus_if.start, 0);
    check("rst_command", bus_if.command, LOAD_SENSING_MATRIX);
    check("rst_read_data", bus_if.read_data, 0);
    check("rst_busy", host_busy, 0);
    check("rst_done", host_done, 0);
    check("rst_error", host_error, 0);
    check("rst_corr_rdata", host_corr_rdata, 0);
    check("rst_mat_addr", mat_addr, 0);
    check("rst_max_value", max_value, 0);
    check("rst_max_index", max_index, 0);
    reset = 1'b0;
    repeat (10) step();
    check("idle_start_never", start_pulses, 0);
    check("idle_busy", host_busy, 0);
    check("idle_read_data", bus_if.read_data, 0);
    check("idle_mat_addr", mat_addr, 0);

    host_op(vs_sensing_matrix_command_t'(2'd3));
    check("unknown_cmd_start", bus_if.start, 0);
    check("unknown_cmd_busy", host_busy, 0);
    step();
    check("unknown_cmd_no_pulse", start_pulses, 0);

    load_matrix(1'b0, "load_addr");
    check("load_single_start", start_pulses, 1);
    check("load_single_done", done_pulses, 1);

    for (int i = 0; i < 7; i++) begin
      host_res_we    = 1'b1;
      host_res_addr  = rv[i].addr;
      host_res_wdata = rv[i].wdata;
      step();
    end
    host_res_we = 1'b0;
    host_op(COMPUTE_INNER_PRODUCTS);
    check("tbl_start", bus_if.start, 1);
    check("tbl_command", bus_if.command, COMPUTE_INNER_PRODUCTS);
    host_res_we    = 1'b1;
    host_res_addr  = 8'd0;
    host_res_wdata = 32'h0000_9999;
    step();
    host_res_we = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bus_if.read_addr = rv[i].addr;
      step();
      check($sformatf("res_read_%0d", rv[i].addr), bus_if.read_data, rv[i].exp);
    end
    fast_writes(COLUMNS, 0);
    finish_op("tbl");
    check("tbl_error", host_error, 0);
    check("tbl_command_held", bus_if.command, COMPUTE_INNER_PRODUCTS);
`ifndef VS_DICT_DRIVER_MAXSCAN_EN
    check("nomax_value", max_value, 0);
    check("nomax_index", max_index, 0);
`endif

    host_op(COMPUTE_INNER_PRODUCTS);
    fast_writes(COLUMNS - 1, 0);
    finish_op("short");
    check("short_error", host_error, 1);
    step();
    check("short_error_sticky", host_error, 1);

    load_matrix(1'b1, "load_cols");
    check("error_kept_over_load", host_error, 1);
    for (int r = 0; r < ROWS; r++) begin
      host_res_we    = 1'b1;
      host_res_addr  = 8'(r);
      host_res_wdata = 32'h0000_8000;
      step();
    end
    host_res_we = 1'b0;
    host_op(COMPUTE_INNER_PRODUCTS);
    check("full_error_cleared", host_error, 0);
    full_compute();
    finish_op("full");
    check("full_error", host_error, 0);
    for (int i = 0; i < 5; i++) begin
      host_corr_addr = cv[i].addr;
      step();
      check($sformatf("corr_%0d", cv[i].addr), host_corr_rdata, cv[i].exp);
    end

`ifdef VS_DICT_DRIVER_MAXSCAN_EN
    host_op(COMPUTE_INNER_PRODUCTS);
    check("max_cleared_value", max_value, 0);
    fast_writes(COLUMNS, 1);
    finish_op("max");
    check("max_index", max_index, 17);
    check("max_value", max_value, 32'hFFFE_8000);
`endif

    host_op(COMPUTE_INNER_PRODUCTS);
    fast_writes(50, 0);
    prev_done = done_pulses;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    check("midrst_busy", host_busy, 0);
    check("midrst_start", bus_if.start, 0);
    check("midrst_done", host_done, 0);
    bus_if.done = 1'b1;
    step();
    bus_if.done = 1'b0;
    step();
    check("idle_done_ignored", done_pulses, prev_done);
    check("idle_done_busy", host_busy, 0);
    host_corr_addr = 8'd10;
    step();
    check("corr_retained", host_corr_rdata, 32'hA000_000A);
    host_op(COMPUTE_INNER_PRODUCTS);
    check("rerun_start", bus_if.start, 1);
    fast_writes(COLUMNS, 0);
    finish_op("rerun");
    check("rerun_error", host_error, 0);
    check("rerun_one_done", done_pulses, prev_done + 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
